load_align_unit: RTL and testbench

Registered load-return stage between the data memory word read port and register-file write-back in the pipelined MIPS core. Each cycle it captures the aligned 32-bit word read from data memory with the MEM-stage instruction, address and PC. It then performs byte/halfword/word extraction with sign or zero extension, and lwl/lwr merging with the old rt value. It also detects misaligned-load address errors. The result is presented to write-back one cycle later, with stall/flush control. It is the read-side counterpart of the store path (sw/sh/sb byte-lane writes) into data memory; memory is little-endian (byte 0 = bits [7:0]).

---
 rtl/load_align_unit.sv | 166 ++++++++++++++++
 tb/tb_load_align_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_align_unit.sv
// -----------------------------------------------------------------------------
// load_align_unit
// Registered load-return stage between the data-memory read port and
// register-file write-back. It captures the aligned memory word with the
// MEM-stage instruction, address and PC. It then extracts the byte, halfword
// or word with sign or zero extension, or merges the word with the old rt
// value for lwl/lwr. It also flags misaligned loads (AdEL). The result is
// presented one cycle later. Memory is little-endian (byte 0 = bits [7:0]).
//
// Parameters:
//   ADDR_CHECK   1 = detect misaligned lh/lhu/lw, 0 = ignore low address bits
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_in_valid   MEM-stage slot holds a real instruction
//   i_ir         MEM-stage instruction (opcode [31:26], rt [20:16])
//   i_pc         MEM-stage instruction PC
//   i_mem_addr   effective byte address
//   i_mem_word   word read from data memory at i_mem_addr[31:2]
//   i_rt_old     forwarded rt value, used by lwl/lwr
//   i_stall      hold all outputs
//   i_flush      kill the instruction being captured (wins over stall)
//   o_out_valid  output slot holds a real instruction
//   o_wb_en      register-file write enable
//   o_wb_reg     destination register
//   o_wb_data    extended/merged load result
//   o_adel       load address error
//   o_bad_vaddr  faulting address when o_adel=1
//   o_out_pc     PC of the held instruction
// -----------------------------------------------------------------------------
module load_align_unit #(
    parameter bit ADDR_CHECK = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    input  logic [31:0] i_ir,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_rt_old,
    input  logic        i_stall,
    input  logic        i_flush,
    output logic        o_out_valid,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_reg,
    output logic [31:0] o_wb_data,
    output logic        o_adel,
    output logic [31:0] o_bad_vaddr,
    output logic [31:0] o_out_pc
);

    typedef enum logic [5:0] {
        OP_LB  = 6'b100000,
        OP_LH  = 6'b100001,
        OP_LWL = 6'b100010,
        OP_LW  = 6'b100011,
        OP_LBU = 6'b100100,
        OP_LHU = 6'b100101,
        OP_LWR = 6'b100110
    } op_e;

    logic [1:0]  w_k;
    logic [4:0]  w_rt;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_is_load;
    logic        w_misal;
    logic [31:0] w_data;
    logic        w_unused;

    assign w_k      = i_mem_addr[1:0];
    assign w_rt     = i_ir[20:16];
    assign w_unused = ^{i_ir[25:21], i_ir[15:0]};

    always_comb begin
        w_byte    = '0;
        w_half    = i_mem_addr[1] ? i_mem_word[31:16] : i_mem_word[15:0];
        w_is_load = 1'b0;
        w_misal   = 1'b0;
        w_data    = '0;

        case (w_k)
            2'd0:    w_byte = i_mem_word[7:0];
            2'd1:    w_byte = i_mem_word[15:8];
            2'd2:    w_byte = i_mem_word[23:16];
            default: w_byte = i_mem_word[31:24];
        endcase

        case (i_ir[31:26])
            OP_LB: begin
                w_is_load = 1'b1;
                w_data    = {{24{w_byte[7]}}, w_byte};
            end
            OP_LBU: begin
                w_is_load = 1'b1;
                w_data    = {24'h0, w_byte};
            end
            OP_LH: begin
                w_is_load = 1'b1;
                w_misal   = ADDR_CHECK && w_k[0];
                w_data    = {{16{w_half[15]}}, w_half};
            end
            OP_LHU: begin
                w_is_load = 1'b1;
                w_misal   = ADDR_CHECK && w_k[0];
                w_data    = {16'h0, w_half};
            end
            OP_LW: begin
                w_is_load = 1'b1;
                w_misal   = ADDR_CHECK && (w_k != 2'd0);
                w_data    = i_mem_word;
            end
            // lwl fills the upper bytes of rt from memory
            OP_LWL: begin
                w_is_load = 1'b1;
                case (w_k)
                    2'd0:    w_data = {i_mem_word[7:0],  i_rt_old[23:0]};
                    2'd1:    w_data = {i_mem_word[15:0], i_rt_old[15:0]};
                    2'd2:    w_data = {i_mem_word[23:0], i_rt_old[7:0]};
                    default: w_data = i_mem_word;
                endcase
            end
            // lwr fills the lower bytes of rt from memory
            OP_LWR: begin
                w_is_load = 1'b1;
                case (w_k)
                    2'd0:    w_data = i_mem_word;
                    2'd1:    w_data = {i_rt_old[31:24], i_mem_word[31:8]};
                    2'd2:    w_data = {i_rt_old[31:16], i_mem_word[31:16]};
                    default: w_data = {i_rt_old[31:8],  i_mem_word[31:24]};
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_out_valid <= 1'b0;
            o_wb_en     <= 1'b0;
            o_wb_reg    <= '0;
            o_wb_data   <= '0;
            o_adel      <= 1'b0;
            o_bad_vaddr <= '0;
            o_out_pc    <= '0;
        end else if (i_flush || (!i_stall && !i_in_valid)) begin
            o_out_valid <= 1'b0;
            o_wb_en     <= 1'b0;
            o_wb_reg    <= '0;
            o_wb_data   <= '0;
            o_adel      <= 1'b0;
            o_bad_vaddr <= '0;
            o_out_pc    <= '0;
        end else if (!i_stall) begin
            o_out_valid <= 1'b1;
            o_wb_en     <= w_is_load && !w_misal && (w_rt != 5'd0);
            o_wb_reg    <= w_rt;
            o_wb_data   <= w_misal ? 32'h0 : w_data;
            o_adel      <= w_is_load && w_misal;
            o_bad_vaddr <= (w_is_load && w_misal) ? i_mem_addr : 32'h0;
            o_out_pc    <= i_pc;
        end
    end

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

    typedef struct packed {
        logic        valid;
        logic        wben;
        logic [4:0]  wbreg;
        logic [31:0] wbdata;
        logic        adel;
        logic [31:0] bad;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, stall, flush;
    logic [31:0] ir, pc, addr, word, rt_old;

    logic        a_valid, a_wben, a_adel;
    logic [4:0]  a_wbreg;
    logic [31:0] a_wbdata, a_bad, a_pc;
    logic        b_valid, b_wben, b_adel;
    logic [4:0]  b_wbreg;
    logic [31:0] b_wbdata, b_bad, b_pc;

    int unsigned total = 0;
    int unsigned bad   = 0;

    exp_t q1[$];
    exp_t q0[$];
    exp_t last1, last0;

    always #5 clk = ~clk;

    load_align_unit #(.ADDR_CHECK(1'b1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_ir(ir),
        .i_pc(pc), .i_mem_addr(addr), .i_mem_word(word), .i_rt_old(rt_old),
        .i_stall(stall), .i_flush(flush),
        .o_out_valid(a_valid), .o_wb_en(a_wben), .o_wb_reg(a_wbreg),
        .o_wb_data(a_wbdata), .o_adel(a_adel), .o_bad_vaddr(a_bad),
        .o_out_pc(a_pc)
    );

    load_align_unit #(.ADDR_CHECK(1'b0)) dut_nc (
        .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(in_valid), .i_ir(ir),
        .i_pc(pc), .i_mem_addr(addr), .i_mem_word(word), .i_rt_old(rt_old),
        .i_stall(stall), .i_flush(flush),
        .o_out_valid(b_valid), .o_wb_en(b_wben), .o_wb_reg(b_wbreg),
        .o_wb_data(b_wbdata), .o_adel(b_adel), .o_bad_vaddr(b_bad),
        .o_out_pc(b_pc)
    );

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_both(input string tag, input exp_t e1, input exp_t e0);
        cmp({tag, ".valid"},  32'(a_valid),  32'(e1.valid));
        cmp({tag, ".wben"},   32'(a_wben),   32'(e1.wben));
        cmp({tag, ".wbreg"},  32'(a_wbreg),  32'(e1.wbreg));
        cmp({tag, ".wbdata"}, a_wbdata,      e1.wbdata);
        cmp({tag, ".adel"},   32'(a_adel),   32'(e1.adel));
        cmp({tag, ".bad"},    a_bad,         e1.bad);
        cmp({tag, ".pc"},     a_pc,          e1.pc);
        cmp({tag, ".nc.valid"},  32'(b_valid), 32'(e0.valid));
        cmp({tag, ".nc.wben"},   32'(b_wben),  32'(e0.wben));
        cmp({tag, ".nc.wbreg"},  32'(b_wbreg), 32'(e0.wbreg));
        cmp({tag, ".nc.wbdata"}, b_wbdata,     e0.wbdata);
        cmp({tag, ".nc.adel"},   32'(b_adel),  32'(e0.adel));
        cmp({tag, ".nc.bad"},    b_bad,        e0.bad);
        cmp({tag, ".nc.pc"},     b_pc,         e0.pc);
    endtask

    // Reference model: shift/mask formulation of the load-return rules.
    function automatic exp_t model(input logic v, input logic [31:0] i_ir,
                                   input logic [31:0] i_pc, input logic [31:0] a,
                                   input logic [31:0] w, input logic [31:0] rt,
                                   input bit chk);
        exp_t        e;
        int unsigned k, sh;
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        logic        ld, mis;
        e = '0;
        if (!v) return e;
        k   = int'(a[1:0]);
        b   = 8'(w >> (8 * k));
        h   = a[1] ? w[31:16] : w[15:0];
        ld  = 1'b1;
        mis = 1'b0;
        res = 32'h0;
        unique case (i_ir[31:26])
            6'b100000: res = 32'(signed'(b));
            6'b100100: res = {24'h0, b};
            6'b100001: begin res = 32'(signed'(h)); mis = chk && a[0]; end
            6'b100101: begin res = {16'h0, h};      mis = chk && a[0]; end
            6'b100011: begin res = w; mis = chk && (a[1:0] != 2'b00); end
            6'b100010: begin
                sh  = 8 * (3 - k);
                res = (w << sh) | (rt & ((32'h1 << sh) - 32'h1));
            end
            6'b100110: begin
                sh  = 8 * k;
                res = (w >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
            end
            default: ld = 1'b0;
        endcase
        e.valid  = 1'b1;
        e.wbreg  = i_ir[20:16];
        e.pc     = i_pc;
        e.adel   = ld && mis;
        e.bad    = (ld && mis) ? a : 32'h0;
        e.wbdata = (ld && !mis) ? res : 32'h0;
        e.wben   = ld && !mis && (i_ir[20:16] != 5'd0);
        return e;
    endfunction

    function automatic logic [31:0] mkir(input logic [5:0] op, input logic [4:0] rt);
        return {op, 5'd3, rt, 16'h0004};
    endfunction

    // Drive one cycle of stimulus, push the expected post-edge state, then
    // pop and compare one edge later.
    task automatic step(input string tag, input logic v, input logic st, input logic fl,
                        input logic [31:0] i_ir, input logic [31:0] i_pc,
                        input logic [31:0] a, input logic [31:0] w, input logic [31:0] rt);
        exp_t e1, e0;
        in_valid = v; stall = st; flush = fl;
        ir = i_ir; pc = i_pc; addr = a; word = w; rt_old = rt;
        if (fl) begin
            last1 = '0; last0 = '0;
        end else if (!st) begin
            last1 = model(v, i_ir, i_pc, a, w, rt, 1'b1);
            last0 = model(v, i_ir, i_pc, a, w, rt, 1'b0);
        end
        q1.push_back(last1);
        q0.push_back(last0);
        @(posedge clk);
        #1;
        e1 = q1.pop_front();
        e0 = q0.pop_front();
        check_both(tag, e1, e0);
    endtask

    localparam logic [31:0] W = 32'h8899AABB;
    localparam logic [31:0] R = 32'h11223344;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t z;
        logic [5:0] ops [8];
        z = '0; last1 = '0; last0 = '0;
        ops[0] = 6'b100000; ops[1] = 6'b100001; ops[2] = 6'b100010; ops[3] = 6'b100011;
        ops[4] = 6'b100100; ops[5] = 6'b100101; ops[6] = 6'b100110; ops[7] = 6'b001000;

        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        ir = '0; pc = '0; addr = '0; word = '0; rt_old = '0;
        #3;
        check_both("reset", z, z);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        step("lb",  1'b1, 1'b0, 1'b0, mkir(6'b100000, 5'd2), 32'h3000, 32'h1001, W, R);
        cmp("lb_const", a_wbdata, 32'hFFFFFFAA);
        cmp("lb_wben", 32'(a_wben), 32'd1);
        step("lbu", 1'b1, 1'b0, 1'b0, mkir(6'b100100, 5'd3), 32'h3004, 32'h1003, W, R);
        cmp("lbu_const", a_wbdata, 32'h00000088);
        step("lh",  1'b1, 1'b0, 1'b0, mkir(6'b100001, 5'd4), 32'h3008, 32'h1002, W, R);
        cmp("lh_const", a_wbdata, 32'hFFFF8899);
        step("lhu", 1'b1, 1'b0, 1'b0, mkir(6'b100101, 5'd5), 32'h300C, 32'h1000, W, R);
        cmp("lhu_const", a_wbdata, 32'h0000AABB);
        step("lwl1", 1'b1, 1'b0, 1'b0, mkir(6'b100010, 5'd6), 32'h3010, 32'h1001, W, R);
        cmp("lwl1_const", a_wbdata, 32'hAABB3344);
        step("lwr2", 1'b1, 1'b0, 1'b0, mkir(6'b100110, 5'd7), 32'h3014, 32'h1002, W, R);
        cmp("lwr2_const", a_wbdata, 32'h11228899);
        step("lwl3", 1'b1, 1'b0, 1'b0, mkir(6'b100010, 5'd8), 32'h3018, 32'h1003, W, R);
        cmp("lwl3_const", a_wbdata, 32'h8899AABB);
        step("lwr0", 1'b1, 1'b0, 1'b0, mkir(6'b100110, 5'd9), 32'h301C, 32'h1000, W, R);
        cmp("lwr0_const", a_wbdata, 32'h8899AABB);

        // misaligned lw: fault with checking, plain word without
        step("lwmis", 1'b1, 1'b0, 1'b0, mkir(6'b100011, 5'd10), 32'h3010, 32'h0102, W, R);
        cmp("lwmis_adel", 32'(a_adel), 32'd1);
        cmp("lwmis_bad",  a_bad, 32'h00000102);
        cmp("lwmis_pc",   a_pc,  32'h00003010);
        cmp("lwmis_wben", 32'(a_wben), 32'd0);
        cmp("lwmis_nc_data", b_wbdata, W);
        cmp("lwmis_nc_adel", 32'(b_adel), 32'd0);

        // back-to-back loads with a 3-cycle stall after the first
        step("b2b_a",  1'b1, 1'b0, 1'b0, mkir(6'b100011, 5'd11), 32'h4000, 32'h2000, 32'hCAFE0001, R);
        step("stall1", 1'b1, 1'b1, 1'b0, mkir(6'b100011, 5'd12), 32'h4004, 32'h2004, 32'hCAFE0002, R);
        step("stall2", 1'b1, 1'b1, 1'b0, mkir(6'b100011, 5'd12), 32'h4004, 32'h2004, 32'hCAFE0002, R);
        step("stall3", 1'b1, 1'b1, 1'b0, mkir(6'b100011, 5'd12), 32'h4004, 32'h2004, 32'hCAFE0002, R);
        cmp("stall_held", a_wbdata, 32'hCAFE0001);
        step("b2b_b",  1'b1, 1'b0, 1'b0, mkir(6'b100011, 5'd12), 32'h4004, 32'h2004, 32'hCAFE0002, R);
        cmp("b2b_b_data", a_wbdata, 32'hCAFE0002);
        step("bubble", 1'b0, 1'b0, 1'b0, mkir(6'b100011, 5'd12), 32'h4004, 32'h2004, 32'hCAFE0002, R);

        // flush beats stall while the slot is full
        step("pre_fl", 1'b1, 1'b0, 1'b0, mkir(6'b100000, 5'd13), 32'h5000, 32'h3000, W, R);
        step("flush",  1'b1, 1'b1, 1'b1, mkir(6'b100000, 5'd13), 32'h5004, 32'h3000, W, R);
        cmp("flush_valid", 32'(a_valid), 32'd0);
        step("lw_r0",  1'b1, 1'b0, 1'b0, mkir(6'b100011, 5'd0), 32'h5008, 32'h3000, W, R);
        cmp("lw_r0_wben", 32'(a_wben), 32'd0);
        step("nonld",  1'b1, 1'b0, 1'b0, mkir(6'b001000, 5'd14), 32'h500C, 32'h3001, W, R);

        // asynchronous reset between edges
        step("pre_rst", 1'b1, 1'b0, 1'b0, mkir(6'b100011, 5'd15), 32'h6000, 32'h4000, 32'h12345678, R);
        #2 rst_n = 1'b0;
        #1 check_both("async_rst", z, z);
        last1 = '0; last0 = '0;
        #2 rst_n = 1'b1;
        step("post_rst", 1'b1, 1'b0, 1'b0, mkir(6'b100011, 5'd16), 32'h6004, 32'h4004, 32'h9ABCDEF0, R);
        cmp("post_rst_data", a_wbdata, 32'h9ABCDEF0);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            step("rand", ($urandom_range(7) != 0), ($urandom_range(3) == 0),
                 ($urandom_range(7) == 0), mkir(ops[$urandom_range(7)], 5'($urandom)),
                 $urandom, $urandom, $urandom, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
